// File: rtl/hazard5_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : hazard5_bus_arbiter
//  Purpose  : Shares one AHB-Lite master port between the instruction fetch
//             port (F) and the load/store port (D). D normally has priority.
//             A starvation counter gives F one priority win after
//             STARVE_LIMIT consecutive D grants while F was waiting. The
//             arbiter tracks address-phase and data-phase ownership
//             separately, so the bus stays fully pipelined.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst                 clock, asynchronous active-high reset
//    f_addr/f_size/f_addr_vld fetch address-phase request
//    f_addr_rdy               fetch address accepted this cycle
//    f_data/f_data_vld        fetch data-phase result
//    d_addr/d_size/d_write    load/store address-phase request
//    d_addr_vld/d_addr_rdy    load/store address handshake
//    d_wdata                  store data, driven during the D data phase
//    d_rdata/d_data_vld       load/store data-phase result
//    ahblm_*                  AHB-Lite master port (IDLE/NONSEQ only)
// ============================================================================
module hazard5_bus_arbiter #(
  parameter int W_ADDR       = 32,
  parameter int W_DATA       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [W_ADDR-1:0] f_addr,
  input  logic              f_size,
  input  logic              f_addr_vld,
  output logic              f_addr_rdy,
  output logic [W_DATA-1:0] f_data,
  output logic              f_data_vld,

  input  logic [W_ADDR-1:0] d_addr,
  input  logic [1:0]        d_size,
  input  logic              d_write,
  input  logic              d_addr_vld,
  output logic              d_addr_rdy,
  input  logic [W_DATA-1:0] d_wdata,
  output logic [W_DATA-1:0] d_rdata,
  output logic              d_data_vld,

  output logic [W_ADDR-1:0] ahblm_haddr,
  output logic              ahblm_hwrite,
  output logic [1:0]        ahblm_htrans,
  output logic [2:0]        ahblm_hsize,
  input  logic              ahblm_hready,
  output logic [W_DATA-1:0] ahblm_hwdata,
  input  logic [W_DATA-1:0] ahblm_hrdata
);

  // Starvation counter width: enough to hold STARVE_LIMIT, never below 1 bit.
  localparam int W_STARVE = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [W_STARVE-1:0] c_starve_max = W_STARVE'(STARVE_LIMIT);
  localparam logic [1:0] c_htrans_idle   = 2'b00;
  localparam logic [1:0] c_htrans_nonseq = 2'b10;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_F    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic                aph_hold_q,  aph_hold_d;
  owner_e              aph_owner_q, aph_owner_d;
  owner_e              dph_owner_q, dph_owner_d;
  logic [W_STARVE-1:0] starve_q,    starve_d;

  owner_e w_grant;
  logic   w_starved;

  // --------------------------------------------------------------------------
  // Grant
  // --------------------------------------------------------------------------
  // The boost only exists when STARVE_LIMIT is nonzero; with a zero limit
  // the counter sits at zero and would otherwise match permanently.
  assign w_starved = (STARVE_LIMIT != 0) && (starve_q == c_starve_max);

  always_comb begin
    w_grant = OWN_NONE;
    if (rst) begin
      // Keep the bus idle while reset is asserted.
      w_grant = OWN_NONE;
    end else if (aph_hold_q) begin
      // An address phase already presented on the bus must stay there until
      // hready; AHB forbids changing a transfer mid-address-phase.
      w_grant = aph_owner_q;
    end else if (w_starved && f_addr_vld) begin
      w_grant = OWN_F;
    end else if (d_addr_vld) begin
      w_grant = OWN_D;
    end else if (f_addr_vld) begin
      w_grant = OWN_F;
    end
  end

  // --------------------------------------------------------------------------
  // Address-phase mux
  // --------------------------------------------------------------------------
  always_comb begin
    ahblm_haddr  = '0;
    ahblm_hwrite = 1'b0;
    ahblm_hsize  = 3'b000;
    ahblm_htrans = c_htrans_idle;
    f_addr_rdy   = 1'b0;
    d_addr_rdy   = 1'b0;
    case (w_grant)
      OWN_F: begin
        ahblm_haddr  = f_addr;
        ahblm_hwrite = 1'b0;
        ahblm_hsize  = f_size ? 3'b010 : 3'b001;
        ahblm_htrans = c_htrans_nonseq;
        f_addr_rdy   = ahblm_hready;
      end
      OWN_D: begin
        ahblm_haddr  = d_addr;
        ahblm_hwrite = d_write;
        ahblm_hsize  = {1'b0, d_size};
        ahblm_htrans = c_htrans_nonseq;
        d_addr_rdy   = ahblm_hready;
      end
      default: begin
        ahblm_htrans = c_htrans_idle;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Data-phase routing
  // --------------------------------------------------------------------------
  // Read data is a straight passthrough; the valid strobes pick the target.
  assign f_data       = ahblm_hrdata;
  assign d_rdata      = ahblm_hrdata;
  assign f_data_vld   = ahblm_hready && (dph_owner_q == OWN_F);
  assign d_data_vld   = ahblm_hready && (dph_owner_q == OWN_D);
  assign ahblm_hwdata = (dph_owner_q == OWN_D) ? d_wdata : '0;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    aph_hold_d  = (w_grant != OWN_NONE) && !ahblm_hready;
    aph_owner_d = w_grant;
    // The address phase accepted this cycle becomes the next data phase;
    // a stalled data phase keeps its owner.
    dph_owner_d = ahblm_hready ? w_grant : dph_owner_q;

    starve_d = starve_q;
    if (!f_addr_vld || (w_grant == OWN_F && ahblm_hready)) begin
      starve_d = '0;
    end else if (ahblm_hready && (w_grant == OWN_D) && (starve_q != c_starve_max)) begin
      starve_d = starve_q + W_STARVE'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aph_hold_q  <= 1'b0;
      aph_owner_q <= OWN_NONE;
      dph_owner_q <= OWN_NONE;
      starve_q    <= '0;
    end else begin
      aph_hold_q  <= aph_hold_d;
      aph_owner_q <= aph_owner_d;
      dph_owner_q <= dph_owner_d;
      starve_q    <= starve_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard5_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard5_bus_arbiter
//  Purpose  : Self-checking bench for hazard5_bus_arbiter. Directed tasks
//             drive each scenario and check address-phase outputs inline;
//             expected data-phase completions are queued at stimulus time
//             and popped by a monitor whenever a data_vld strobe fires.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hazard5_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] f_addr = '0;
  logic        f_size = 1'b0;
  logic        f_addr_vld = 1'b0;
  logic        f_addr_rdy;
  logic [31:0] f_data;
  logic        f_data_vld;
  logic [31:0] d_addr = '0;
  logic [1:0]  d_size = '0;
  logic        d_write = 1'b0;
  logic        d_addr_vld = 1'b0;
  logic        d_addr_rdy;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_data_vld;
  logic [31:0] ahblm_haddr;
  logic        ahblm_hwrite;
  logic [1:0]  ahblm_htrans;
  logic [2:0]  ahblm_hsize;
  logic        ahblm_hready = 1'b1;
  logic [31:0] ahblm_hwdata;
  logic [31:0] ahblm_hrdata = '0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          is_d;
    bit          is_write;
    logic [31:0] wdata;
  } exp_t;
  exp_t sb[$];

  hazard5_bus_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .f_addr       (f_addr),
    .f_size       (f_size),
    .f_addr_vld   (f_addr_vld),
    .f_addr_rdy   (f_addr_rdy),
    .f_data       (f_data),
    .f_data_vld   (f_data_vld),
    .d_addr       (d_addr),
    .d_size       (d_size),
    .d_write      (d_write),
    .d_addr_vld   (d_addr_vld),
    .d_addr_rdy   (d_addr_rdy),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_data_vld   (d_data_vld),
    .ahblm_haddr  (ahblm_haddr),
    .ahblm_hwrite (ahblm_hwrite),
    .ahblm_htrans (ahblm_htrans),
    .ahblm_hsize  (ahblm_hsize),
    .ahblm_hready (ahblm_hready),
    .ahblm_hwdata (ahblm_hwdata),
    .ahblm_hrdata (ahblm_hrdata)
  );

  always #5 clk = ~clk;

  // Fresh read data every cycle so passthrough is exercised with new values.
  always @(negedge clk) ahblm_hrdata = $urandom;

  // Data-phase monitor: samples mid low phase, after the tasks' drives.
  always begin
    @(negedge clk);
    #3;
    if (f_data_vld || d_data_vld) begin
      checks++;
      if (f_data_vld && d_data_vld) begin
        errors++;
        $display("FAIL dph_both_vld: f_data_vld=%0b d_data_vld=%0b, required one-hot", f_data_vld, d_data_vld);
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL dph_unexpected: f_data_vld=%0b d_data_vld=%0b, required no completion", f_data_vld, d_data_vld);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (d_data_vld !== e.is_d) begin
          errors++;
          $display("FAIL dph_port: got d_data_vld=%0b, required %0b", d_data_vld, e.is_d);
        end else if (e.is_d && d_rdata !== ahblm_hrdata) begin
          errors++;
          $display("FAIL dph_d_rdata: got %h, required %h", d_rdata, ahblm_hrdata);
        end else if (!e.is_d && f_data !== ahblm_hrdata) begin
          errors++;
          $display("FAIL dph_f_data: got %h, required %h", f_data, ahblm_hrdata);
        end else if (e.is_write && ahblm_hwdata !== e.wdata) begin
          errors++;
          $display("FAIL dph_hwdata: got %h, required %h", ahblm_hwdata, e.wdata);
        end
      end
    end
  end

  task automatic idle_inputs();
    f_addr_vld   = 1'b0;
    d_addr_vld   = 1'b0;
    d_write      = 1'b0;
    ahblm_hready = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if (ahblm_htrans !== 2'b00 || f_addr_rdy !== 1'b0 || d_addr_rdy !== 1'b0 ||
        f_data_vld !== 1'b0 || d_data_vld !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: htrans=%b f_rdy=%b d_rdy=%b fv=%b dv=%b, required 00 0 0 0 0",
               ahblm_htrans, f_addr_rdy, d_addr_rdy, f_data_vld, d_data_vld);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (ahblm_htrans !== 2'b00 || ahblm_haddr !== 32'h0 || ahblm_hsize !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle: htrans=%b haddr=%h hsize=%b, required 00 0 000",
               ahblm_htrans, ahblm_haddr, ahblm_hsize);
    end
  endtask

  task automatic test_fetch_single();
    @(negedge clk);
    f_addr = 32'h100; f_size = 1'b1; f_addr_vld = 1'b1; ahblm_hready = 1'b1;
    #1;
    checks++;
    if (ahblm_htrans !== 2'b10 || ahblm_haddr !== 32'h100 || ahblm_hsize !== 3'b010 ||
        ahblm_hwrite !== 1'b0 || f_addr_rdy !== 1'b1 || d_addr_rdy !== 1'b0) begin
      errors++;
      $display("FAIL fetch_aph: htrans=%b haddr=%h hsize=%b hwrite=%b f_rdy=%b d_rdy=%b, required 10 100 010 0 1 0",
               ahblm_htrans, ahblm_haddr, ahblm_hsize, ahblm_hwrite, f_addr_rdy, d_addr_rdy);
    end
    sb.push_back('{is_d: 1'b0, is_write: 1'b0, wdata: 32'h0});
    @(negedge clk);
    f_addr_vld = 1'b0;
    #1;
    checks++;
    if (f_data_vld !== 1'b1 || ahblm_htrans !== 2'b00) begin
      errors++;
      $display("FAIL fetch_dph: f_data_vld=%b htrans=%b, required 1 00", f_data_vld, ahblm_htrans);
    end
  endtask

  task automatic test_contention();
    @(negedge clk);
    f_addr = 32'h104; f_size = 1'b0; f_addr_vld = 1'b1;
    d_addr = 32'h2000; d_size = 2'd2; d_write = 1'b1; d_addr_vld = 1'b1;
    #1;
    checks++;
    if (ahblm_haddr !== 32'h2000 || ahblm_hwrite !== 1'b1 || ahblm_hsize !== 3'b010 ||
        d_addr_rdy !== 1'b1 || f_addr_rdy !== 1'b0) begin
      errors++;
      $display("FAIL contention_d_first: haddr=%h hwrite=%b hsize=%b d_rdy=%b f_rdy=%b, required 2000 1 010 1 0",
               ahblm_haddr, ahblm_hwrite, ahblm_hsize, d_addr_rdy, f_addr_rdy);
    end
    sb.push_back('{is_d: 1'b1, is_write: 1'b1, wdata: 32'hCAFEF00D});
    @(negedge clk);
    d_addr_vld = 1'b0; d_write = 1'b0; d_wdata = 32'hCAFEF00D;
    #1;
    checks++;
    if (ahblm_haddr !== 32'h104 || ahblm_hsize !== 3'b001 || ahblm_hwrite !== 1'b0 ||
        f_addr_rdy !== 1'b1 || ahblm_hwdata !== 32'hCAFEF00D || d_data_vld !== 1'b1) begin
      errors++;
      $display("FAIL contention_f_second: haddr=%h hsize=%b hwrite=%b f_rdy=%b hwdata=%h dv=%b, required 104 001 0 1 cafef00d 1",
               ahblm_haddr, ahblm_hsize, ahblm_hwrite, f_addr_rdy, ahblm_hwdata, d_data_vld);
    end
    sb.push_back('{is_d: 1'b0, is_write: 1'b0, wdata: 32'h0});
    @(negedge clk);
    f_addr_vld = 1'b0;
    #1;
    checks++;
    if (f_data_vld !== 1'b1 || ahblm_hwdata !== 32'h0) begin
      errors++;
      $display("FAIL contention_f_dph: f_data_vld=%b hwdata=%h, required 1 0", f_data_vld, ahblm_hwdata);
    end
  endtask

  task automatic test_hold();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      f_addr = 32'h200; f_size = 1'b1; f_addr_vld = 1'b1; ahblm_hready = 1'b0;
      if (c >= 1) begin
        d_addr = 32'h3000; d_size = 2'd0; d_write = 1'b0; d_addr_vld = 1'b1;
      end
      #1;
      checks++;
      if (ahblm_haddr !== 32'h200 || ahblm_htrans !== 2'b10 || d_addr_rdy !== 1'b0 || f_addr_rdy !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: haddr=%h htrans=%b d_rdy=%b f_rdy=%b, required 200 10 0 0",
                 c, ahblm_haddr, ahblm_htrans, d_addr_rdy, f_addr_rdy);
      end
    end
    @(negedge clk);
    ahblm_hready = 1'b1;
    #1;
    checks++;
    if (ahblm_haddr !== 32'h200 || f_addr_rdy !== 1'b1 || d_addr_rdy !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: haddr=%h f_rdy=%b d_rdy=%b, required 200 1 0", ahblm_haddr, f_addr_rdy, d_addr_rdy);
    end
    sb.push_back('{is_d: 1'b0, is_write: 1'b0, wdata: 32'h0});
    @(negedge clk);
    f_addr_vld = 1'b0;
    #1;
    checks++;
    if (ahblm_haddr !== 32'h3000 || ahblm_hsize !== 3'b000 || d_addr_rdy !== 1'b1 || f_data_vld !== 1'b1) begin
      errors++;
      $display("FAIL hold_then_d: haddr=%h hsize=%b d_rdy=%b fv=%b, required 3000 000 1 1",
               ahblm_haddr, ahblm_hsize, d_addr_rdy, f_data_vld);
    end
    sb.push_back('{is_d: 1'b1, is_write: 1'b0, wdata: 32'h0});
    @(negedge clk);
    d_addr_vld = 1'b0;
    #1;
    checks++;
    if (d_data_vld !== 1'b1) begin
      errors++;
      $display("FAIL hold_d_dph: d_data_vld=%b, required 1", d_data_vld);
    end
  endtask

  task automatic test_starvation();
    // Expected grant order with limit 4: D D D D F D.
    bit exp_d [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      f_addr = 32'h500; f_size = 1'b1; f_addr_vld = 1'b1;
      d_addr = 32'h4000; d_size = 2'd1; d_write = 1'b0; d_addr_vld = 1'b1;
      ahblm_hready = 1'b1;
      #1;
      checks++;
      if (d_addr_rdy !== exp_d[c] || f_addr_rdy !== !exp_d[c] ||
          ahblm_haddr !== (exp_d[c] ? 32'h4000 : 32'h500)) begin
        errors++;
        $display("FAIL starve_grant%0d: d_rdy=%b f_rdy=%b haddr=%h, required d_rdy=%b",
                 c, d_addr_rdy, f_addr_rdy, ahblm_haddr, exp_d[c]);
      end
      sb.push_back('{is_d: exp_d[c], is_write: 1'b0, wdata: 32'h0});
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    d_addr = 32'h3004; d_size = 2'd2; d_write = 1'b1; d_addr_vld = 1'b1; ahblm_hready = 1'b1;
    #1;
    checks++;
    if (d_addr_rdy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_d_aph: d_rdy=%b, required 1", d_addr_rdy);
    end
    sb.push_back('{is_d: 1'b1, is_write: 1'b1, wdata: 32'h5A5A1234});
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      d_addr_vld = 1'b0; d_write = 1'b0; d_wdata = 32'h5A5A1234;
      f_addr = 32'h400; f_size = 1'b1; f_addr_vld = 1'b1; ahblm_hready = 1'b0;
      #1;
      checks++;
      if (d_data_vld !== 1'b0 || f_addr_rdy !== 1'b0 || ahblm_haddr !== 32'h400 || ahblm_hwdata !== 32'h5A5A1234) begin
        errors++;
        $display("FAIL b2b_stall%0d: dv=%b f_rdy=%b haddr=%h hwdata=%h, required 0 0 400 5a5a1234",
                 c, d_data_vld, f_addr_rdy, ahblm_haddr, ahblm_hwdata);
      end
    end
    @(negedge clk);
    ahblm_hready = 1'b1;
    #1;
    checks++;
    if (d_data_vld !== 1'b1 || f_addr_rdy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_release: dv=%b f_rdy=%b, required 1 1", d_data_vld, f_addr_rdy);
    end
    sb.push_back('{is_d: 1'b0, is_write: 1'b0, wdata: 32'h0});
    @(negedge clk);
    f_addr_vld = 1'b0;
    #1;
    checks++;
    if (f_data_vld !== 1'b1 || d_data_vld !== 1'b0) begin
      errors++;
      $display("FAIL b2b_f_dph: fv=%b dv=%b, required 1 0", f_data_vld, d_data_vld);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    f_addr = 32'h600; f_size = 1'b1; f_addr_vld = 1'b1; ahblm_hready = 1'b1;
    @(negedge clk);
    f_addr_vld = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (ahblm_htrans !== 2'b00 || f_data_vld !== 1'b0 || d_data_vld !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: htrans=%b fv=%b dv=%b, required 00 0 0", ahblm_htrans, f_data_vld, d_data_vld);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (f_data_vld !== 1'b0 || d_data_vld !== 1'b0 || ahblm_htrans !== 2'b00) begin
        errors++;
        $display("FAIL reset_stale%0d: fv=%b dv=%b htrans=%b, required 0 0 00", c, f_data_vld, d_data_vld, ahblm_htrans);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch_single();
    test_contention();
    test_hold();
    test_starvation();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d completions outstanding, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard5_bus_arbiter.md
Name: hazard5_bus_arbiter

Overview:
Two-master to one-AHB-Lite-master arbiter that shares the single processor bus between the instruction frontend (fetch port) and the load/store unit (data port). Each requester uses the split address/data handshake of the frontend fetch interface. The arbiter tracks address-phase and data-phase ownership and returns data to the correct requester. Data port has priority, with a bounded fetch-starvation guard.

Parameters:
W_ADDR, 32, address width (only 32 supported)
W_DATA, 32, data width (only 32 supported)
STARVE_LIMIT, 4, consecutive data-port grants while fetch waits before fetch gets priority once; 0 = fetch boost disabled
W_STARVE, $clog2(STARVE_LIMIT+1) (min 1), starvation counter width (derived)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
f_addr  in  W_ADDR  fetch address
f_size  in  1  1 = 32-bit fetch, 0 = 16-bit
f_addr_vld  in  1  fetch address request
f_addr_rdy  out  1  fetch address accepted this cycle
f_data  out  W_DATA  fetch read data
f_data_vld  out  1  fetch data-phase completes this cycle
d_addr  in  W_ADDR  load/store address
d_size  in  2  0 byte, 1 half, 2 word
d_write  in  1  1 = store
d_addr_vld  in  1  load/store address request
d_addr_rdy  out  1  load/store address accepted
d_wdata  in  W_DATA  store data, driven by requester during its data phase
d_rdata  out  W_DATA  load data
d_data_vld  out  1  load/store data-phase completes
ahblm_haddr  out  W_ADDR  bus address
ahblm_hwrite  out  1  bus write
ahblm_htrans  out  2  IDLE 2'b00 / NONSEQ 2'b10 only
ahblm_hsize  out  3  bus transfer size
ahblm_hready  in  1  bus ready
ahblm_hwdata  out  W_DATA  bus write data
ahblm_hrdata  in  W_DATA  bus read data

Behaviour:
- Clock clk; reset rst is asynchronous, active-high. Reset: aph_hold=0, aph_owner=NONE, dph_owner=NONE, starve_ctr=0, so htrans=IDLE, both addr_rdy=0, both data_vld=0.
- Grant (combinational). If aph_hold: grant=aph_owner, unconditionally. Else if starve_ctr==STARVE_LIMIT and STARVE_LIMIT!=0 and f_addr_vld: grant=F. Else if d_addr_vld: grant=D. Else if f_addr_vld: grant=F. Else NONE.
- Address mux:
  - grant F: haddr=f_addr, hwrite=0, hsize=f_size?3'b010:3'b001.
  - grant D: haddr=d_addr, hwrite=d_write, hsize={1'b0,d_size}.
  - grant NONE: htrans=IDLE, haddr/hsize=0.
  - htrans=NONSEQ whenever grant!=NONE.
- Granted port's addr_rdy=ahblm_hready; ungranted port's addr_rdy=0.
- Hold register, updated every cycle:
  - aph_hold <= (grant!=NONE) && !hready.
  - aph_owner <= grant.
  - Requesters keep address stable until addr_rdy, so a held grant is never withdrawn. A higher-priority request arriving during a hold waits.
- Data phase, on hready: dph_owner <= grant (NONE if idle). While hready is low, dph_owner holds.
  - f_data_vld = hready && dph_owner==F.
  - d_data_vld = hready && dph_owner==D.
  - f_data=d_rdata=hrdata (passthrough).
  - hwdata=d_wdata when dph_owner==D, else 0.
  - Pipelined: a new address phase is accepted in the same cycle as a data phase completes. Zero added latency; data arrives the cycle hready is high in the data phase.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on each cycle with hready && grant==D && f_addr_vld.
  - Clears when F address is accepted, or when f_addr_vld is low.
  - At STARVE_LIMIT, fetch wins the next free arbitration. Counter clears on that acceptance.
- No error response handling. The arbiter never drops or reorders transfers. At most one outstanding data phase.
- Reset mid-transfer: ownership is lost. Neither data_vld is asserted after reset until a new grant.

Test Plan:
- Idle then f_addr_vld with f_addr=0x100, hready=1 -> cycle0: htrans=2'b10, haddr=0x100, hsize=3'b010, f_addr_rdy=1. Cycle1: f_data_vld=1, f_data=hrdata.
- f_addr_vld and d_addr_vld same cycle (d_addr=0x2000, d_write=1, d_size=2) -> D granted first, hwrite=1, hwdata=d_wdata next cycle. F granted the following cycle.
- F granted with hready=0 for 3 cycles, d_addr_vld rising in cycle 1 -> haddr stays F's address, d_addr_rdy=0 throughout. D granted only after F accepted.
- STARVE_LIMIT=4, f_addr_vld and d_addr_vld held high, hready=1 -> 4 D grants, then 1 F grant, then D again. starve_ctr reads 4 then 0.
- Back-to-back D, F with hready low for 2 cycles in D's data phase -> d_data_vld pulses once when hready returns high. F's address is accepted in that same cycle, and f_data_vld follows one cycle later.
- Assert rst during an F data phase -> immediately htrans=0, f_data_vld=0, d_data_vld=0. After release, no stale data_vld.
